// File: rtl/reg_space_arbiter.sv
// reg_space_arbiter: round-robin arbiter that puts two register-access masters onto one
// register-space request port. One transaction is in flight at a time. A watchdog
// error-completes any access the slave stalls, so a master is never locked out.
module reg_space_arbiter #(
    parameter int            AW       = 16,
    parameter int            DW       = 32,
    parameter int            TIMEOUT  = 256,
    parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m0_rreq_addr,
    input  logic          m0_rreq_vld,
    output logic          m0_rreq_rdy,
    output logic [DW-1:0] m0_rack_data,
    output logic          m0_rack_vld,
    input  logic          m0_rack_rdy,
    input  logic [AW-1:0] m0_wreq_addr,
    input  logic [DW-1:0] m0_wreq_data,
    input  logic          m0_wreq_vld,
    output logic          m0_wreq_rdy,
    output logic          m0_err,
    input  logic [AW-1:0] m1_rreq_addr,
    input  logic          m1_rreq_vld,
    output logic          m1_rreq_rdy,
    output logic [DW-1:0] m1_rack_data,
    output logic          m1_rack_vld,
    input  logic          m1_rack_rdy,
    input  logic [AW-1:0] m1_wreq_addr,
    input  logic [DW-1:0] m1_wreq_data,
    input  logic          m1_wreq_vld,
    output logic          m1_wreq_rdy,
    output logic          m1_err,
    output logic [AW-1:0] s_rreq_addr,
    output logic          s_rreq_vld,
    input  logic          s_rreq_rdy,
    input  logic [DW-1:0] s_rack_data,
    input  logic          s_rack_vld,
    output logic          s_rack_rdy,
    output logic [AW-1:0] s_wreq_addr,
    output logic [DW-1:0] s_wreq_data,
    output logic          s_wreq_vld,
    input  logic          s_wreq_rdy,
    output logic [1:0]    gnt
);

    // TIMEOUT=0 would give a zero-width counter; keep one bit that simply never moves.
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
    localparam bit            WDOG_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, RD, WR, RD_ERR} state_t;

    state_t        state, state_nxt;
    logic [1:0]    gnt_q, gnt_nxt;
    logic          rr, rr_nxt;       // index of the master favoured at the next pick
    logic [CW-1:0] cnt;

    // Per-master views, index 0 = m0, 1 = m1.
    logic [1:0][AW-1:0] rreq_addr, wreq_addr;
    logic [1:0][DW-1:0] wreq_data, rack_data;
    logic [1:0]         rreq_vld, wreq_vld, rack_rdy;
    logic [1:0]         rreq_rdy, rack_vld, wreq_rdy, err;
    logic [1:0]         req;
    logic               pick, g, wdog_fire;

    // Read completion is defined by the ack handshake, so the request ready is not needed.
    logic unused_s_rreq_rdy;
    assign unused_s_rreq_rdy = s_rreq_rdy;

    assign rreq_addr = {m1_rreq_addr, m0_rreq_addr};
    assign wreq_addr = {m1_wreq_addr, m0_wreq_addr};
    assign wreq_data = {m1_wreq_data, m0_wreq_data};
    assign rreq_vld  = {m1_rreq_vld, m0_rreq_vld};
    assign wreq_vld  = {m1_wreq_vld, m0_wreq_vld};
    assign rack_rdy  = {m1_rack_rdy, m0_rack_rdy};

    assign req       = rreq_vld | wreq_vld;
    assign pick      = rr ? req[1] : ~req[0];
    assign g         = gnt_q[1];
    assign wdog_fire = WDOG_EN && (cnt == CNT_LAST);

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt_q <= 2'b00;
            rr    <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt_q <= gnt_nxt;
            rr    <= rr_nxt;
        end
    end

    // Watchdog counter: runs while a slave access is outstanding, saturates, cleared otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == RD || state == WR) begin
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Arbitration, slave-port muxing and completion / timeout decisions.
    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt_q;
        rr_nxt      = rr;
        s_rreq_addr = '0;
        s_rreq_vld  = 1'b0;
        s_rack_rdy  = 1'b0;
        s_wreq_addr = '0;
        s_wreq_data = '0;
        s_wreq_vld  = 1'b0;
        rreq_rdy    = '0;
        rack_vld    = '0;
        rack_data   = '0;
        wreq_rdy    = '0;
        err         = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_nxt   = pick ? 2'b10 : 2'b01;
                    rr_nxt    = ~pick;
                    state_nxt = rreq_vld[pick] ? RD : WR;
                end
            end
            RD: begin
                s_rreq_vld   = 1'b1;
                s_rreq_addr  = rreq_addr[g];
                s_rack_rdy   = rack_rdy[g];
                rack_vld[g]  = s_rack_vld;
                rack_data[g] = s_rack_data;
                if (s_rack_vld && rack_rdy[g]) begin
                    rreq_rdy[g] = 1'b1;
                    state_nxt   = IDLE;
                    gnt_nxt     = 2'b00;
                end else if (wdog_fire) begin
                    state_nxt = RD_ERR;
                end
            end
            WR: begin
                s_wreq_vld  = 1'b1;
                s_wreq_addr = wreq_addr[g];
                s_wreq_data = wreq_data[g];
                if (s_wreq_rdy) begin
                    wreq_rdy[g] = 1'b1;
                    state_nxt   = IDLE;
                    gnt_nxt     = 2'b00;
                end else if (wdog_fire) begin
                    wreq_rdy[g] = 1'b1;
                    err[g]      = 1'b1;
                    state_nxt   = IDLE;
                    gnt_nxt     = 2'b00;
                end
            end
            RD_ERR: begin
                // Slave side is released; the master sees a synthetic error ack.
                rack_vld[g]  = 1'b1;
                rack_data[g] = ERR_DATA;
                if (rack_rdy[g]) begin
                    rreq_rdy[g] = 1'b1;
                    err[g]      = 1'b1;
                    state_nxt   = IDLE;
                    gnt_nxt     = 2'b00;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
            end
        endcase
    end

    assign gnt          = gnt_q;
    assign m0_rreq_rdy  = rreq_rdy[0];
    assign m0_rack_vld  = rack_vld[0];
    assign m0_rack_data = rack_data[0];
    assign m0_wreq_rdy  = wreq_rdy[0];
    assign m0_err       = err[0];
    assign m1_rreq_rdy  = rreq_rdy[1];
    assign m1_rack_vld  = rack_vld[1];
    assign m1_rack_data = rack_data[1];
    assign m1_wreq_rdy  = wreq_rdy[1];
    assign m1_err       = err[1];

endmodule

// File: tb/tb_reg_space_arbiter.sv
// tb_reg_space_arbiter: directed and randomized checks of the two-master register arbiter.
module tb_reg_space_arbiter;

    localparam int          T    = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] m0_rreq_addr, m1_rreq_addr, m0_wreq_addr, m1_wreq_addr;
    logic [31:0] m0_wreq_data, m1_wreq_data, m0_rack_data, m1_rack_data;
    logic        m0_rreq_vld, m0_rreq_rdy, m0_rack_vld, m0_rack_rdy, m0_wreq_vld, m0_wreq_rdy, m0_err;
    logic        m1_rreq_vld, m1_rreq_rdy, m1_rack_vld, m1_rack_rdy, m1_wreq_vld, m1_wreq_rdy, m1_err;
    logic [15:0] s_rreq_addr, s_wreq_addr;
    logic [31:0] s_rack_data, s_wreq_data;
    logic        s_rreq_vld, s_rreq_rdy, s_rack_vld, s_rack_rdy, s_wreq_vld, s_wreq_rdy;
    logic [1:0]  gnt;
    logic [140:0] outs;

    int checks   = 0;
    int failures = 0;
    int exp_rr   = 0;

    always #5 clk = ~clk;

    assign outs = {m0_rreq_rdy, m0_rack_data, m0_rack_vld, m0_wreq_rdy, m0_err,
                   m1_rreq_rdy, m1_rack_data, m1_rack_vld, m1_wreq_rdy, m1_err,
                   s_rreq_addr, s_rreq_vld, s_rack_rdy, s_wreq_addr, s_wreq_data, s_wreq_vld, gnt};

    reg_space_arbiter #(.AW(16), .DW(32), .TIMEOUT(T), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst(rst),
        .m0_rreq_addr(m0_rreq_addr), .m0_rreq_vld(m0_rreq_vld), .m0_rreq_rdy(m0_rreq_rdy),
        .m0_rack_data(m0_rack_data), .m0_rack_vld(m0_rack_vld), .m0_rack_rdy(m0_rack_rdy),
        .m0_wreq_addr(m0_wreq_addr), .m0_wreq_data(m0_wreq_data), .m0_wreq_vld(m0_wreq_vld),
        .m0_wreq_rdy(m0_wreq_rdy), .m0_err(m0_err),
        .m1_rreq_addr(m1_rreq_addr), .m1_rreq_vld(m1_rreq_vld), .m1_rreq_rdy(m1_rreq_rdy),
        .m1_rack_data(m1_rack_data), .m1_rack_vld(m1_rack_vld), .m1_rack_rdy(m1_rack_rdy),
        .m1_wreq_addr(m1_wreq_addr), .m1_wreq_data(m1_wreq_data), .m1_wreq_vld(m1_wreq_vld),
        .m1_wreq_rdy(m1_wreq_rdy), .m1_err(m1_err),
        .s_rreq_addr(s_rreq_addr), .s_rreq_vld(s_rreq_vld), .s_rreq_rdy(s_rreq_rdy),
        .s_rack_data(s_rack_data), .s_rack_vld(s_rack_vld), .s_rack_rdy(s_rack_rdy),
        .s_wreq_addr(s_wreq_addr), .s_wreq_data(s_wreq_data), .s_wreq_vld(s_wreq_vld),
        .s_wreq_rdy(s_wreq_rdy), .gnt(gnt)
    );

    function automatic logic f_rreq_rdy(input int m);
        return (m == 0) ? m0_rreq_rdy : m1_rreq_rdy;
    endfunction
    function automatic logic f_wreq_rdy(input int m);
        return (m == 0) ? m0_wreq_rdy : m1_wreq_rdy;
    endfunction
    function automatic logic f_rack_vld(input int m);
        return (m == 0) ? m0_rack_vld : m1_rack_vld;
    endfunction
    function automatic logic [31:0] f_rack_data(input int m);
        return (m == 0) ? m0_rack_data : m1_rack_data;
    endfunction
    function automatic logic f_err(input int m);
        return (m == 0) ? m0_err : m1_err;
    endfunction
    function automatic logic f_any(input int m);
        return f_rreq_rdy(m) | f_wreq_rdy(m) | f_rack_vld(m) | (|f_rack_data(m)) | f_err(m);
    endfunction

    task automatic set_req(input int m, input logic rv, input logic [15:0] ra,
                           input logic wv, input logic [15:0] wa, input logic [31:0] wd);
        if (m == 0) begin
            m0_rreq_vld = rv; m0_rreq_addr = ra; m0_wreq_vld = wv; m0_wreq_addr = wa; m0_wreq_data = wd;
        end else begin
            m1_rreq_vld = rv; m1_rreq_addr = ra; m1_wreq_vld = wv; m1_wreq_addr = wa; m1_wreq_data = wd;
        end
    endtask

    task automatic set_rack_rdy(input int m, input logic v);
        if (m == 0) m0_rack_rdy = v;
        else        m1_rack_rdy = v;
    endtask

    task automatic clr_in();
        set_req(0, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        set_req(1, 1'b0, 16'h0, 1'b0, 16'h0, 32'h0);
        m0_rack_rdy = 1'b0; m1_rack_rdy = 1'b0;
        s_rreq_rdy = 1'b0; s_rack_vld = 1'b0; s_rack_data = 32'h0; s_wreq_rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clr_in();
        @(negedge clk);
        rst = 1'b0;
        exp_rr = 0;
    endtask

    // One isolated transaction. Slave acks after 'lat' cycles of its request valid; master
    // holds rack_rdy low for 'hold' cycles of rack_vld. Entered and left at a negedge.
    task automatic run_txn(input int m, input bit rd, input logic [15:0] a, input logic [31:0] d,
                           input int lat, input int hold,
                           output int svld_n, output int errp, output int errdata_n,
                           output logic [31:0] rdata, output logic [1:0] gnt_s,
                           output logic [15:0] saddr, output logic [31:0] swdata,
                           output bit done, output int stray);
        int   nrv;
        logic rv;
        svld_n = 0; errp = 0; errdata_n = 0; rdata = '0; gnt_s = '0; saddr = '0; swdata = '0;
        done = 1'b0; stray = 0; nrv = 0;
        if (rd) set_req(m, 1'b1, a, 1'b0, 16'h0, 32'h0);
        else    set_req(m, 1'b0, 16'h0, 1'b1, a, d);
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            s_rack_vld = 1'b0; s_rack_data = 32'h0; s_wreq_rdy = 1'b0;
            if (s_rreq_vld || s_wreq_vld) begin
                if (svld_n == 0) begin
                    gnt_s  = gnt;
                    saddr  = rd ? s_rreq_addr : s_wreq_addr;
                    swdata = s_wreq_data;
                end
                if (s_rreq_vld) begin
                    s_rack_vld  = (svld_n >= lat);
                    s_rack_data = d;
                end
                if (s_wreq_vld) s_wreq_rdy = (svld_n >= lat);
                svld_n++;
            end
            #1;
            rv = f_rack_vld(m);
            set_rack_rdy(m, rv && (nrv >= hold));
            #1;
            if (rv && !s_rreq_vld && f_rack_data(m) == ERRD) errdata_n++;
            nrv += int'(rv);
            if (f_any(1 - m) || (s_rreq_vld && s_wreq_vld)) stray++;
            errp += int'(f_err(m));
            if (f_rreq_rdy(m) || f_wreq_rdy(m)) begin
                done  = 1'b1;
                rdata = f_rack_data(m);
            end
            @(negedge clk);
        end
        clr_in();
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 16'h0010, 1'b0, 16'h0, 32'h0);
        set_req(1, 1'b0, 16'h0, 1'b1, 16'h0020, 32'h5555_AAAA);
        s_rack_vld = 1'b1; s_wreq_rdy = 1'b1; s_rack_data = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
        checks++;
        if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        rst = 1'b0;
        clr_in();
        @(negedge clk);
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL idle_outs got=%h exp=0", outs); end
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int svn, ep, edn, st; logic [31:0] rdv, wdv; logic [1:0] gs; logic [15:0] sa; bit dn;
        do_reset();
        run_txn(0, 1'b1, 16'h0000, 32'h1234_5678, 0, 0, svn, ep, edn, rdv, gs, sa, wdv, dn, st);
        checks++;
        if (!dn || svn != 1) begin failures++; $display("FAIL single_rd_done got=%0d/%0d exp=1/1", dn, svn); end
        checks++;
        if (gs !== 2'b01) begin failures++; $display("FAIL single_rd_gnt got=%b exp=01", gs); end
        checks++;
        if (sa !== 16'h0000) begin failures++; $display("FAIL single_rd_addr got=%h exp=0000", sa); end
        checks++;
        if (rdv !== 32'h1234_5678) begin failures++; $display("FAIL single_rd_data got=%h exp=12345678", rdv); end
        checks++;
        if (ep != 0 || st != 0) begin failures++; $display("FAIL single_rd_err got=%0d/%0d exp=0/0", ep, st); end
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL single_rd_idle got=%h exp=0", outs); end
    endtask

    task automatic test_rr_reads();
        logic [1:0] eg;
        do_reset();
        set_req(0, 1'b1, 16'h0010, 1'b0, 16'h0, 32'h0);
        set_req(1, 1'b1, 16'h0014, 1'b0, 16'h0, 32'h0);
        m0_rack_rdy = 1'b1; m1_rack_rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            s_rack_vld  = s_rreq_vld;
            s_rack_data = 32'h0BAD_0000 + 32'(c);
            #1;
            // Grants every other cycle, alternating m0, m1, m0, m1.
            eg = (c % 2 != 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if (gnt !== eg) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
        end
        clr_in();
    endtask

    task automatic test_same_master_rw();
        int          nev;
        bit          ev_wr[4];
        logic [15:0] ev_addr[4];
        logic [31:0] ev_data[4];
        logic [31:0] wd;
        bit          pr, pw;
        do_reset();
        wd = $urandom;
        pr = 1'b1; pw = 1'b1; nev = 0;
        set_req(1, 1'b1, 16'h0020, 1'b1, 16'h0040, wd);
        m1_rack_rdy = 1'b1;
        for (int c = 0; c < 12 && (pr || pw); c++) begin
            #1;
            s_rack_vld = s_rreq_vld; s_rack_data = 32'h0F0F_0020; s_wreq_rdy = s_wreq_vld;
            #1;
            if ((m1_rreq_rdy || m1_wreq_rdy) && nev < 4) begin
                ev_wr[nev]   = m1_wreq_rdy;
                ev_addr[nev] = m1_wreq_rdy ? s_wreq_addr : s_rreq_addr;
                ev_data[nev] = m1_wreq_rdy ? s_wreq_data : m1_rack_data;
                nev++;
            end
            if (m1_rreq_rdy) pr = 1'b0;
            if (m1_wreq_rdy) pw = 1'b0;
            @(negedge clk);
            set_req(1, pr, 16'h0020, pw, 16'h0040, wd);
        end
        clr_in();
        checks++;
        if (nev != 2) begin failures++; $display("FAIL rw_count got=%0d exp=2", nev); end
        else begin
            checks++;
            if (ev_wr[0] !== 1'b0 || ev_addr[0] !== 16'h0020 || ev_data[0] !== 32'h0F0F_0020) begin
                failures++;
                $display("FAIL rw_first got=wr%0d/%h/%h exp=wr0/0020/0f0f0020", ev_wr[0], ev_addr[0], ev_data[0]);
            end
            checks++;
            if (ev_wr[1] !== 1'b1 || ev_addr[1] !== 16'h0040 || ev_data[1] !== wd) begin
                failures++;
                $display("FAIL rw_second got=wr%0d/%h/%h exp=wr1/0040/%h", ev_wr[1], ev_addr[1], ev_data[1], wd);
            end
        end
    endtask

    task automatic test_timeouts();
        int svn, ep, edn, st; logic [31:0] rdv, wdv; logic [1:0] gs; logic [15:0] sa; bit dn;
        do_reset();
        run_txn(0, 1'b0, 16'h0104, 32'hCAFE_0001, 1000, 0, svn, ep, edn, rdv, gs, sa, wdv, dn, st);
        checks++;
        if (!dn || svn != T || ep != 1) begin
            failures++; $display("FAIL wr_timeout got=done%0d vld%0d err%0d exp=done1 vld%0d err1", dn, svn, ep, T);
        end
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL wr_timeout_idle got=%h exp=0", outs); end
        run_txn(1, 1'b1, 16'h0200, 32'h1111_2222, 1000, 3, svn, ep, edn, rdv, gs, sa, wdv, dn, st);
        checks++;
        if (!dn || svn != T || ep != 1 || edn != 4 || rdv !== ERRD) begin
            failures++;
            $display("FAIL rd_timeout got=done%0d vld%0d err%0d errcyc%0d data%h exp=done1 vld%0d err1 errcyc4 data%h",
                     dn, svn, ep, edn, rdv, T, ERRD);
        end
        run_txn(0, 1'b0, 16'h0300, 32'h7777_0000, T - 1, 0, svn, ep, edn, rdv, gs, sa, wdv, dn, st);
        checks++;
        if (!dn || svn != T || ep != 0) begin
            failures++; $display("FAIL wr_last_cycle got=done%0d vld%0d err%0d exp=done1 vld%0d err0", dn, svn, ep, T);
        end
        run_txn(1, 1'b1, 16'h0304, 32'h7777_1111, T - 1, 0, svn, ep, edn, rdv, gs, sa, wdv, dn, st);
        checks++;
        if (!dn || svn != T || ep != 0 || rdv !== 32'h7777_1111) begin
            failures++; $display("FAIL rd_last_cycle got=done%0d vld%0d err%0d data%h exp=done1 vld%0d err0 data77771111",
                                 dn, svn, ep, rdv, T);
        end
    endtask

    task automatic test_reset_mid_rd();
        int svn, ep, edn, st; logic [31:0] rdv, wdv; logic [1:0] gs; logic [15:0] sa; bit dn;
        do_reset();
        // m0 is served once so that m1 would be favoured if reset failed to clear the pointer.
        run_txn(0, 1'b1, 16'h0008, 32'h0000_0001, 0, 0, svn, ep, edn, rdv, gs, sa, wdv, dn, st);
        set_req(0, 1'b1, 16'h0044, 1'b0, 16'h0, 32'h0);
        repeat (3) @(negedge clk);
        set_req(1, 1'b1, 16'h0048, 1'b0, 16'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL rst_mid_rd_outs got=%h exp=0", outs); end
        @(negedge clk);
        #1;
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL rst_mid_rd_favour got=%b exp=01", gnt); end
        clr_in();
        do_reset();
    endtask

    task automatic test_random();
        int svn, ep, edn, st; logic [31:0] rdv, wdv; logic [1:0] gs; logic [15:0] sa; bit dn;
        int m, lat, hold, e_sv, e_err, e_ed, rdlen;
        bit rd;
        logic [15:0] a;
        logic [31:0] d, e_data;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            m    = int'($urandom_range(0, 1));
            rd   = 1'($urandom_range(0, 1));
            a    = 16'($urandom);
            d    = $urandom;
            lat  = int'($urandom_range(0, 11));
            hold = rd ? int'($urandom_range(0, 3)) : 0;
            if (rd) begin
                if (lat + hold < T) begin
                    e_sv = lat + hold + 1; e_err = 0; e_data = d; e_ed = 0;
                end else begin
                    rdlen = (T > lat) ? T - lat : 0;
                    e_sv = T; e_err = 1; e_data = ERRD;
                    e_ed = 1 + ((hold > rdlen) ? hold - rdlen : 0);
                end
            end else begin
                e_sv = (lat < T) ? lat + 1 : T; e_err = (lat < T) ? 0 : 1; e_data = '0; e_ed = 0;
            end
            run_txn(m, rd, a, d, lat, hold, svn, ep, edn, rdv, gs, sa, wdv, dn, st);
            checks++;
            if (!dn || svn != e_sv || ep != e_err || st != 0) begin
                failures++;
                $display("FAIL rnd%0d_ctrl got=done%0d vld%0d err%0d stray%0d exp=done1 vld%0d err%0d stray0",
                         i, dn, svn, ep, st, e_sv, e_err);
            end
            checks++;
            if (gs !== ((m == 1) ? 2'b10 : 2'b01) || sa !== a) begin
                failures++; $display("FAIL rnd%0d_route got=%b/%h exp=m%0d/%h", i, gs, sa, m, a);
            end
            checks++;
            if (rd && (rdv !== e_data || edn != e_ed)) begin
                failures++; $display("FAIL rnd%0d_rdata got=%h/%0d exp=%h/%0d", i, rdv, edn, e_data, e_ed);
            end else if (!rd && wdv !== d) begin
                failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, wdv, d);
            end
        end
    endtask

    task automatic test_contention();
        for (int r = 0; r < 12; r++) begin
            bit          rq[2], wq[2], pr[2], pw[2];
            logic [15:0] ra[2], wa[2];
            logic [31:0] wd[2];
            int          expq[$], obsq[$];
            int          fav, p, bad, seq_bad;
            for (int m = 0; m < 2; m++) begin
                rq[m] = 1'($urandom_range(0, 1));
                wq[m] = 1'($urandom_range(0, 1));
                ra[m] = 16'($urandom);
                wa[m] = 16'($urandom);
                wd[m] = $urandom;
            end
            if (!(rq[0] | wq[0] | rq[1] | wq[1])) rq[0] = 1'b1;
            // Reference order: favoured master if it has work, reads before writes, then swap favour.
            expq.delete();
            pr = rq; pw = wq; fav = exp_rr;
            while (pr[0] | pw[0] | pr[1] | pw[1]) begin
                p = (pr[fav] | pw[fav]) ? fav : 1 - fav;
                if (pr[p]) begin expq.push_back(p * 2);     pr[p] = 1'b0; end
                else       begin expq.push_back(p * 2 + 1); pw[p] = 1'b0; end
                fav = 1 - p;
            end
            exp_rr = fav;
            obsq.delete();
            bad = 0;
            pr = rq; pw = wq;
            for (int m = 0; m < 2; m++) set_req(m, pr[m], ra[m], pw[m], wa[m], wd[m]);
            m0_rack_rdy = 1'b1; m1_rack_rdy = 1'b1;
            for (int c = 0; c < 24 && (pr[0] | pw[0] | pr[1] | pw[1]); c++) begin
                #1;
                s_rack_vld = s_rreq_vld; s_rack_data = 32'h600D_0000; s_wreq_rdy = s_wreq_vld;
                #1;
                for (int m = 0; m < 2; m++) begin
                    if (f_rreq_rdy(m)) begin
                        obsq.push_back(m * 2); pr[m] = 1'b0;
                        if (s_rreq_addr !== ra[m]) bad++;
                    end
                    if (f_wreq_rdy(m)) begin
                        obsq.push_back(m * 2 + 1); pw[m] = 1'b0;
                        if (s_wreq_addr !== wa[m] || s_wreq_data !== wd[m]) bad++;
                    end
                end
                @(negedge clk);
                for (int m = 0; m < 2; m++) set_req(m, pr[m], ra[m], pw[m], wa[m], wd[m]);
            end
            clr_in();
            seq_bad = (obsq.size() != expq.size()) ? 1 : 0;
            for (int k = 0; k < obsq.size() && k < expq.size(); k++)
                if (obsq[k] != expq[k]) seq_bad = 1;
            checks++;
            if (seq_bad != 0) begin
                failures++;
                $display("FAIL contend%0d_order got=%p exp=%p", r, obsq, expq);
            end
            checks++;
            if (bad != 0) begin failures++; $display("FAIL contend%0d_payload got=%0d bad exp=0", r, bad); end
        end
    endtask

    initial begin
        clr_in();
        test_reset();
        test_single_read();
        test_rr_reads();
        test_same_master_rw();
        test_timeouts();
        test_reset_mid_rd();
        test_random();
        do_reset();
        test_contention();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/reg_space_arbiter.md
# reg_space_arbiter

Arbitrates two register-access masters onto the single read/write request port of a `RegSpaceBase_*` register space. One transaction is in flight at a time. Masters are served round-robin, with read before write within a master. A per-transaction watchdog completes any stalled access with an error, so an unresponsive slave cannot lock a master; for example, write-disabled spaces hold `wreq_rdy` at 0. The block sits between the bus bridges (APB bridge, debug master) and the register space.

## Interface
Parameters:
- `AW`, 16: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 256: cycles in RD/WR before an error completion. 0 disables the watchdog.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on timeout.

Ports (mN = m0, m1):
- `clk` in 1: clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `mN_rreq_addr` in AW, `mN_rreq_vld` in 1, `mN_rreq_rdy` out 1: master read request.
- `mN_rack_data` out DW, `mN_rack_vld` out 1, `mN_rack_rdy` in 1: master read acknowledge.
- `mN_wreq_addr` in AW, `mN_wreq_data` in DW, `mN_wreq_vld` in 1, `mN_wreq_rdy` out 1: master write request.
- `mN_err` out 1: one-cycle pulse on a timed-out completion.
- `s_rreq_addr` out AW, `s_rreq_vld` out 1, `s_rreq_rdy` in 1: register-space read request.
- `s_rack_data` in DW, `s_rack_vld` in 1, `s_rack_rdy` out 1: register-space read acknowledge.
- `s_wreq_addr` out AW, `s_wreq_data` out DW, `s_wreq_vld` out 1, `s_wreq_rdy` in 1: register-space write request.
- `gnt` out 2: one-hot current owner (bit0 = m0). 0 in IDLE.

## Operation
- Masters hold `vld` and payload stable until the matching `rdy`/completion. Withdrawal before completion is a protocol violation and the resulting behaviour is undefined.
- FSM states: IDLE, RD, WR, RD_ERR.
- **IDLE**
  - Candidate masters are those with `rreq_vld|wreq_vld`.
  - The pick favours master `rr`; the other master is taken only if the favoured one has no request.
  - Within the picked master, a read wins over a write.
  - Register the grant (`gnt`, `is_rd`) and set `rr` to the non-granted master. Go to RD or WR. Clear `cnt`.
- **RD**
  - `s_rreq_vld=1`; `s_rreq_addr` = granted master's address.
  - `s_rack_rdy` = granted `rack_rdy`; granted `rack_vld`/`rack_data` = `s_rack_*`.
  - Completion is `s_rack_vld & s_rack_rdy`. In that cycle, pulse granted `rreq_rdy` and go to IDLE.
- **WR**
  - `s_wreq_vld=1`; addr/data muxed from the granted master.
  - Completion is `s_wreq_vld & s_wreq_rdy`. In that cycle, pulse granted `wreq_rdy` and go to IDLE.
- **Watchdog**
  - `cnt` increments each cycle in RD/WR and saturates at TIMEOUT.
  - Timeout fires when `TIMEOUT!=0`, `cnt==TIMEOUT-1`, and no completion occurs in that cycle. A completion in the same cycle wins.
  - WR timeout: pulse granted `wreq_rdy` and `err`, go to IDLE.
  - RD timeout: go to RD_ERR.
- **RD_ERR**
  - `s_rreq_vld=0`, `s_rack_rdy=0`.
  - Granted `rack_vld=1`, `rack_data=ERR_DATA`.
  - On granted `rack_rdy`: pulse `rreq_rdy` and `err`, go to IDLE.
- Non-granted master outputs are all 0 at all times. `mN_rack_data` is 0 when that master is not in RD/RD_ERR.
- `s_rreq_rdy` is informational only. Read completion is defined by the ack handshake, matching the register space, where `rreq_rdy = rack_vld & rack_rdy`.

## Timing
- Reset, effective on the next `clk` edge regardless of state (including mid-RD/WR):
  - State returns to IDLE; `cnt=0`; `rr=0` (m0 favoured).
  - Every output is 0.
  - An interrupted slave access is abandoned. Masters must re-issue.
- Grant latency: a request seen in IDLE at cycle t drives the slave at t+1.
- One IDLE bubble separates transactions. Minimum back-to-back period is 2 cycles for a zero-wait slave.
- Read path is combinational: `s_rack_data`/`vld` to `mN_rack_*`, and `mN_rack_rdy` to `s_rack_rdy`. No added read-data latency.
- `mN_rreq_rdy`, `mN_wreq_rdy` and `mN_err` are single-cycle pulses, coincident with the completing handshake.
- Counter width: `$clog2(TIMEOUT+1)`. It never wraps.

## Test plan
- m0 reads addr 16'h0000 and the slave acks 0x12345678 one cycle after grant. Required: `gnt=01`, `s_rreq_addr=0`, `m0_rack_data=0x12345678`, and `m0_rreq_rdy` pulses in the same cycle. Back in IDLE the next cycle.
- After reset, m0 and m1 both request reads continuously. Required grant order: m0, m1, m0, m1, with 2-cycle spacing for a zero-wait slave.
- m1 asserts read (addr 16'h0020) and write in the same cycle. Required: read served first, then the write, with `s_wreq_data` equal to m1's data.
- TIMEOUT=8, m0 write, `s_wreq_rdy` held 0. Required: `s_wreq_vld` high for exactly 8 cycles, then `m0_wreq_rdy` and `m0_err` pulse together, and `s_wreq_vld` drops.
- TIMEOUT=8, m1 read, `s_rack_vld` held 0, `m1_rack_rdy` low for 3 extra cycles. Required: `m1_rack_data=0xDEADBEEF` held with `vld` until `rdy`, then `m1_err` and `m1_rreq_rdy` pulse. A completion landing exactly on cycle 8 is normal, with no `err`.
- `rst` asserted during RD. Required: all outputs 0 on the next cycle, state IDLE, m0 favoured in the next arbitration.
